// File: rtl/y86_seq_controller_pkg.sv
// y86_pkg: shared Y86-64 icode/stat constants, controller state type and helpers
package y86_pkg;
  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WB, PCUP, HALT, ERROR} state_t;
  function automatic logic is_mem_icode(input logic [3:0] ic);
    return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction
endpackage

// File: rtl/y86_seq_controller_if.sv
// y86_seq_controller_if: stage handshake, enables, status and counters of the sequencer
interface y86_seq_controller_if #(parameter int CNT_W = 32);
  logic start, step_mode, instruct_err, mem_err, mem_ready;
  logic [3:0] icode;
  logic en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc, busy;
  logic [2:0] stat;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
  modport master (
    output start, step_mode, icode, instruct_err, mem_err, mem_ready,
    input  en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc, busy, stat, cycle_cnt, instr_cnt
  );
  modport slave (
    input  start, step_mode, icode, instruct_err, mem_err, mem_ready,
    output en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc, busy, stat, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/y86_seq_controller_mem_wait_timer.sv
// y86_mem_wait_timer: counts MEMORY cycles, flags the last allowed cycle before an address error
module y86_mem_wait_timer #(parameter int MEM_TIMEOUT = 15) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  // cnt holds completed MEMORY cycles, so this is high during the MEM_TIMEOUT-th one
  assign timeout = cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/y86_seq_controller.sv
// y86_seq_controller: multi-cycle Y86-64 stage sequencer with memory stall, fault detection and counters
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  y86_seq_controller_if.slave bus
);
  state_t state, nxt;
  logic [2:0] nstat;
  logic [3:0] icode_q;
  logic timeout;
  y86_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk),
    .rst(reset),
    .clr(state == EXECUTE),
    .en(state == MEMORY),
    .timeout(timeout)
  );
  always_comb begin
    nxt = state;
    nstat = bus.stat;
    case (state)
      IDLE: nxt = bus.start ? FETCH : IDLE;
      FETCH: begin
        nxt = bus.mem_err || bus.instruct_err ? ERROR : bus.icode == IHALT ? HALT : DECODE;
        nstat = bus.mem_err ? ADR : bus.instruct_err ? INS : bus.icode == IHALT ? HLT : bus.stat;
      end
      DECODE: nxt = EXECUTE;
      EXECUTE: nxt = MEMORY;
      MEMORY: begin
        // mem_err wins over a simultaneous mem_ready; non-memory icodes pass straight through
        if (!is_mem_icode(icode_q)) nxt = WB;
        else if (bus.mem_err || (!bus.mem_ready && timeout)) begin
          nxt = ERROR;
          nstat = ADR;
        end else if (bus.mem_ready) nxt = WB;
      end
      WB: nxt = PCUP;
      PCUP: nxt = bus.step_mode ? IDLE : FETCH;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      icode_q <= '0;
      bus.stat <= AOK;
      bus.en_fetch <= 1'b0;
      bus.en_decode <= 1'b0;
      bus.en_execute <= 1'b0;
      bus.en_memory <= 1'b0;
      bus.en_wb <= 1'b0;
      bus.en_pc <= 1'b0;
      bus.busy <= 1'b0;
      bus.cycle_cnt <= '0;
      bus.instr_cnt <= '0;
    end else begin
      state <= nxt;
      bus.stat <= nstat;
      if (state == FETCH) icode_q <= bus.icode;
      bus.en_fetch <= nxt == FETCH;
      bus.en_decode <= nxt == DECODE;
      bus.en_execute <= nxt == EXECUTE;
      bus.en_memory <= nxt == MEMORY;
      bus.en_wb <= nxt == WB;
      bus.en_pc <= nxt == PCUP;
      bus.busy <= !(nxt inside {IDLE, HALT, ERROR});
      if (bus.busy && !(&bus.cycle_cnt)) bus.cycle_cnt <= bus.cycle_cnt + CNT_W'(1);
      if (state == PCUP && !(&bus.instr_cnt)) bus.instr_cnt <= bus.instr_cnt + CNT_W'(1);
    end
endmodule
